// File: rtl/processor_top_pkg.sv
`default_nettype none
// ============================================================================
// processor_top_pkg : opcodes, constants and default program for processor_top
// Revision: 1.0
// ============================================================================
package processor_top_pkg;

    localparam int         c_REG_IDX_W  = 2;
    localparam logic [7:0] c_INT_VECTOR = 8'hF0;
    localparam logic [7:0] c_NOP        = 8'h00;

    localparam logic [3:0] c_OP_MOV = 4'h1;
    localparam logic [3:0] c_OP_ADD = 4'h2;
    localparam logic [3:0] c_OP_SUB = 4'h3;
    localparam logic [3:0] c_OP_AND = 4'h4;
    localparam logic [3:0] c_OP_OR  = 4'h5;
    localparam logic [3:0] c_OP_INC = 4'h6;
    localparam logic [3:0] c_OP_DEC = 4'h7;
    localparam logic [3:0] c_OP_OUT = 4'h8;
    localparam logic [3:0] c_OP_IN  = 4'h9;
    localparam logic [3:0] c_OP_LDM = 4'hA;
    localparam logic [3:0] c_OP_JZ  = 4'hB;
    localparam logic [3:0] c_OP_JMP = 4'hC;
    localparam logic [3:0] c_OP_JC  = 4'hD;
    localparam logic [3:0] c_OP_RTI = 4'hE;
    localparam logic [3:0] c_OP_HLT = 4'hF;

    // Built-in image of fib.mem: Fibonacci generator plus a bare RTI as the ISR
    function automatic logic [7:0] fib_rom(input logic [7:0] addr);
        logic [7:0] v;
        case (addr)
            8'h00:   v = 8'hA0;
            8'h01:   v = 8'h00;
            8'h02:   v = 8'hA4;
            8'h03:   v = 8'h01;
            8'h04:   v = 8'hAC;
            8'h05:   v = 8'h06;
            8'h06:   v = 8'h80;
            8'h07:   v = 8'h19;
            8'h08:   v = 8'h24;
            8'h09:   v = 8'h12;
            8'h0A:   v = 8'hC3;
            8'hF0:   v = 8'hE0;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_alu.sv
`default_nettype none
// ============================================================================
// proc_alu : combinational ALU for processor_top (MOV and ops 2-7)
// Revision: 1.0
// ============================================================================
module proc_alu
    import processor_top_pkg::*;
(
    input  logic [3:0] i_op,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_result,
    output logic       o_z,
    output logic       o_c,
    output logic       o_n
);

    logic [8:0] w_wide;
    logic [7:0] w_res;
    logic       w_c;

    // Bit 8 of the 9-bit difference is the borrow for SUB and DEC
    always_comb begin
        w_wide = {1'b0, i_b};
        w_res  = i_b;
        w_c    = i_cin;
        case (i_op)
            c_OP_ADD: begin
                w_wide = {1'b0, i_a} + {1'b0, i_b};
                w_res  = w_wide[7:0];
                w_c    = w_wide[8];
            end
            c_OP_SUB: begin
                w_wide = {1'b0, i_a} - {1'b0, i_b};
                w_res  = w_wide[7:0];
                w_c    = w_wide[8];
            end
            c_OP_AND: begin
                w_res = i_a & i_b;
                w_c   = 1'b0;
            end
            c_OP_OR: begin
                w_res = i_a | i_b;
                w_c   = 1'b0;
            end
            c_OP_INC: begin
                w_wide = {1'b0, i_a} + 9'd1;
                w_res  = w_wide[7:0];
                w_c    = w_wide[8];
            end
            c_OP_DEC: begin
                w_wide = {1'b0, i_a} - 9'd1;
                w_res  = w_wide[7:0];
                w_c    = w_wide[8];
            end
            default: begin
                w_res = i_b;
                w_c   = i_cin;
            end
        endcase
    end

    assign o_result = w_res;
    assign o_z      = (w_res == 8'h00);
    assign o_c      = w_c;
    assign o_n      = w_res[7];

endmodule
`default_nettype wire

// File: rtl/processor_top.sv
`default_nettype none
// ============================================================================
// processor_top : 8-bit two-stage (IF/EX) CPU with ROM, 4 registers, one IRQ
// Revision: 1.0
// ============================================================================
module processor_top
    import processor_top_pkg::*;
#(
    parameter string          ROM_INIT   = "fib.mem",
    parameter logic [7:0]     INT_VECTOR = c_INT_VECTOR,
    parameter logic [2047:0]  ROM_IMAGE  = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] IN_Port,
    input  logic       Interrupt,
    output logic [7:0] Result_Debug,
    output logic [7:0] PC_Debug,
    output logic       Valid,
    output logic [7:0] OUT_Port
);

    // The default file name selects the built-in program; any other name uses ROM_IMAGE
    localparam bit c_USE_FIB = (ROM_INIT == "fib.mem");

    logic [7:0] r_pc, r_ir, r_epc, r_out, r_result;
    logic [7:0] r_regs [4];
    logic       r_flag_z, r_flag_c, r_flag_n;
    logic       r_sv_z, r_sv_c, r_sv_n;
    logic       r_valid, r_pend, r_mask, r_int_prev;

    logic [3:0]             w_op;
    logic [c_REG_IDX_W-1:0] w_ra, w_rb;
    logic [7:0]             w_a, w_b, w_rom_data, w_alu_res, w_wr_data;
    logic                   w_alu_z, w_alu_c, w_alu_n, w_alu_op, w_wr_en;
    logic                   w_z_nxt, w_c_nxt, w_n_nxt;
    logic                   w_br_taken, w_no_int, w_int_take, w_int_rise;

    assign w_rom_data = c_USE_FIB ? fib_rom(r_pc) : ROM_IMAGE[{r_pc, 3'b000} +: 8];

    assign w_op = r_ir[7:4];
    assign w_ra = r_ir[3:2];
    assign w_rb = r_ir[1:0];
    assign w_a  = r_regs[w_ra];
    assign w_b  = r_regs[w_rb];

    proc_alu u_alu (
        .i_op     (w_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .i_cin    (r_flag_c),
        .o_result (w_alu_res),
        .o_z      (w_alu_z),
        .o_c      (w_alu_c),
        .o_n      (w_alu_n)
    );

    assign w_alu_op  = (w_op >= c_OP_ADD) && (w_op <= c_OP_DEC);
    assign w_wr_en   = w_alu_op || (w_op == c_OP_MOV) || (w_op == c_OP_IN) || (w_op == c_OP_LDM);
    assign w_wr_data = (w_op == c_OP_IN)  ? IN_Port :
                       (w_op == c_OP_LDM) ? w_rom_data : w_alu_res;

    // Flags as they stand once the current instruction completes
    assign w_z_nxt = (w_op == c_OP_RTI) ? r_sv_z : (w_alu_op ? w_alu_z : r_flag_z);
    assign w_c_nxt = (w_op == c_OP_RTI) ? r_sv_c : (w_alu_op ? w_alu_c : r_flag_c);
    assign w_n_nxt = (w_op == c_OP_RTI) ? r_sv_n : (w_alu_op ? w_alu_n : r_flag_n);

    assign w_br_taken = (w_op == c_OP_JMP) || ((w_op == c_OP_JZ) && r_flag_z)
                     || ((w_op == c_OP_JC) && r_flag_c);
    assign w_no_int   = (w_op == c_OP_LDM) || (w_op == c_OP_JZ) || (w_op == c_OP_JMP)
                     || (w_op == c_OP_JC) || (w_op == c_OP_RTI);
    assign w_int_take = r_pend && !w_no_int;
    assign w_int_rise = Interrupt && !r_int_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= 8'h00;
            r_ir       <= c_NOP;
            r_epc      <= 8'h00;
            r_out      <= 8'h00;
            r_result   <= 8'h00;
            for (int i = 0; i < 4; i++) r_regs[i] <= 8'h00;
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
            r_flag_n   <= 1'b0;
            r_sv_z     <= 1'b0;
            r_sv_c     <= 1'b0;
            r_sv_n     <= 1'b0;
            r_valid    <= 1'b0;
            r_pend     <= 1'b0;
            r_mask     <= 1'b0;
            r_int_prev <= 1'b0;
        end else begin
            r_int_prev <= Interrupt;
            r_valid    <= (w_op == c_OP_OUT);
            if (w_op == c_OP_OUT) r_out <= w_b;
            if (w_wr_en) begin
                r_regs[w_ra] <= w_wr_data;
                r_result     <= w_wr_data;
            end
            r_flag_z <= w_z_nxt;
            r_flag_c <= w_c_nxt;
            r_flag_n <= w_n_nxt;

            if (w_int_take) begin
                // The instruction being fetched is dropped and refetched after RTI
                r_epc  <= r_pc;
                r_sv_z <= w_z_nxt;
                r_sv_c <= w_c_nxt;
                r_sv_n <= w_n_nxt;
                r_pc   <= INT_VECTOR;
                r_ir   <= c_NOP;
                r_pend <= 1'b0;
                r_mask <= 1'b1;
            end else begin
                if (w_int_rise && !r_mask) r_pend <= 1'b1;
                if (w_op == c_OP_HLT) begin
                    r_pc <= r_pc;
                    r_ir <= r_ir;
                end else if (w_op == c_OP_RTI) begin
                    r_pc   <= r_epc;
                    r_ir   <= c_NOP;
                    r_mask <= 1'b0;
                end else if (w_br_taken) begin
                    r_pc <= w_b;
                    r_ir <= c_NOP;
                end else if (w_op == c_OP_LDM) begin
                    r_pc <= r_pc + 8'd1;
                    r_ir <= c_NOP;
                end else begin
                    r_pc <= r_pc + 8'd1;
                    r_ir <= w_rom_data;
                end
            end
        end
    end

    assign Result_Debug = r_result;
    assign PC_Debug     = r_pc;
    assign Valid        = r_valid;
    assign OUT_Port     = r_out;

endmodule
`default_nettype wire

// File: tb/tb_processor_top.sv
`default_nettype none
// ============================================================================
// tb_processor_top : scoreboard bench for processor_top (default and custom ROM)
// Revision: 1.0
// ============================================================================
module tb_processor_top;

    function automatic logic [2047:0] build_img();
        logic [2047:0] r;
        r = '0;
        r[0   +: 8] = 8'h94;   // IN  R1
        r[8   +: 8] = 8'h81;   // OUT R1
        r[16  +: 8] = 8'hA4;   // LDM R1,20
        r[24  +: 8] = 8'h20;
        r[32  +: 8] = 8'hA0;   // LDM R0,FF
        r[40  +: 8] = 8'hFF;
        r[48  +: 8] = 8'h60;   // INC R0
        r[56  +: 8] = 8'hD1;   // JC  R1
        r[256 +: 8] = 8'hF0;   // 20: HLT
        r[272 +: 8] = 8'hF0;   // 22: HLT
        r[1920 +: 8] = 8'hE0;  // F0: RTI
        return r;
    endfunction

    localparam logic [2047:0] c_IMG = build_img();

    logic       clk, rst, rst_c, intr, intr_c;
    logic [7:0] in_port, in_port_c;
    logic [7:0] res, pc, outp, res_c, pc_c, outp_c;
    logic       valid, valid_c;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [7:0] exp_q [$];
    int         vtimes [$];

    processor_top dut (
        .clk          (clk),
        .rst          (rst),
        .IN_Port      (in_port),
        .Interrupt    (intr),
        .Result_Debug (res),
        .PC_Debug     (pc),
        .Valid        (valid),
        .OUT_Port     (outp)
    );

    processor_top #(.ROM_INIT("custom.mem"), .ROM_IMAGE(c_IMG)) dut_c (
        .clk          (clk),
        .rst          (rst_c),
        .IN_Port      (in_port_c),
        .Interrupt    (intr_c),
        .Result_Debug (res_c),
        .PC_Debug     (pc_c),
        .Valid        (valid_c),
        .OUT_Port     (outp_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%02h required=%02h", name, got, req);
        end
    endtask

    // Scoreboard monitor: every Valid pulse pops one expected OUT_Port value
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            logic [7:0] e;
            vtimes.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected got=%0d required=no_output", outp);
            end else begin
                e = exp_q.pop_front();
                if (outp !== e) begin
                    failures++;
                    $display("FAIL out_value got=%0d required=%0d", outp, e);
                end
            end
        end
    end

    task automatic push_fib(input int count);
        logic [7:0] a, b, t;
        a = 8'd0;
        b = 8'd1;
        for (int i = 0; i < count; i++) begin
            exp_q.push_back(a);
            t = a + b;
            a = b;
            b = t;
        end
    endtask

    task automatic drain(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, 8'(exp_q.size()), 8'd0);
        exp_q.delete();
    endtask

    initial begin
        int k, bad, seen, n;
        rst = 1'b0; rst_c = 1'b0; intr = 1'b0; intr_c = 1'b0;
        in_port = 8'h00; in_port_c = 8'h5A;

        // Reset state and free-running Fibonacci output
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 8'h00);
        chk("rst_out", outp, 8'h00);
        chk("rst_valid", {7'b0, valid}, 8'h00);
        chk("rst_result", res, 8'h00);
        vtimes.delete();
        push_fib(16);
        k = cyc;
        rst = 1'b1;
        drain("fib_drain", 200);
        if (vtimes.size() >= 2) begin
            chk("first_valid_cycle", 8'(vtimes[0] - k), 8'd8);
            bad = 0;
            for (int i = 1; i < vtimes.size(); i++)
                if (vtimes[i] - vtimes[i-1] != 6) bad++;
            chk("valid_period_errors", 8'(bad), 8'd0);
        end else begin
            chk("valid_count", 8'(vtimes.size()), 8'd16);
        end

        // Mid-run reset restarts the program
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_pc", pc, 8'h00);
        chk("midrst_out", outp, 8'h00);
        chk("midrst_valid", {7'b0, valid}, 8'h00);
        rst = 1'b1;
        push_fib(12);

        // Interrupt during the loop, then a masked second edge inside the ISR
        seen = 0;
        n = 0;
        while (seen < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (valid === 1'b1) seen++;
        end
        chk("sync_third_out", 8'(seen), 8'd3);
        chk("irq_pc_at_out", pc, 8'h08);
        intr = 1'b1;
        @(negedge clk); chk("irq_pc_pend", pc, 8'h09); intr = 1'b0;
        @(negedge clk); chk("irq_pc_vector", pc, 8'hF0); intr = 1'b1;
        @(negedge clk); chk("irq_pc_isr", pc, 8'hF1); intr = 1'b0;
        @(negedge clk); chk("irq_pc_return", pc, 8'h09);
        @(negedge clk); chk("irq_pc_resume", pc, 8'h0A);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (pc == 8'hF0) bad++;
        end
        chk("irq_reentry", 8'(bad), 8'd0);
        drain("irq_fib_drain", 150);

        // Custom ROM: IN/OUT, LDM/INC/JC, HLT with interrupt wake-up
        rst = 1'b0;
        rst_c = 1'b1;
        @(negedge clk); chk("c_pc_e1", pc_c, 8'h01);
        @(negedge clk); chk("c_in_result", res_c, 8'h5A); chk("c_valid_pre", {7'b0, valid_c}, 8'h00);
        @(negedge clk); chk("c_out_port", outp_c, 8'h5A); chk("c_valid_on", {7'b0, valid_c}, 8'h01);
        @(negedge clk); chk("c_valid_off", {7'b0, valid_c}, 8'h00); chk("c_out_hold", outp_c, 8'h5A);
        chk("c_ldm_result", res_c, 8'h20);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("c_inc_result", res_c, 8'h00);
        chk("c_flag_z", {7'b0, dut_c.r_flag_z}, 8'h01);
        chk("c_flag_c", {7'b0, dut_c.r_flag_c}, 8'h01);
        @(negedge clk); chk("c_jc_target", pc_c, 8'h20);
        @(negedge clk); chk("c_after_bubble", pc_c, 8'h21);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (pc_c != 8'h21) bad++;
        end
        chk("c_hlt_hold_errors", 8'(bad), 8'd0);
        intr_c = 1'b1;
        @(negedge clk); chk("c_hlt_pend", pc_c, 8'h21); intr_c = 1'b0;
        @(negedge clk); chk("c_hlt_vector", pc_c, 8'hF0);
        @(negedge clk); chk("c_hlt_isr", pc_c, 8'hF1);
        @(negedge clk); chk("c_rti_return", pc_c, 8'h21);
        @(negedge clk); chk("c_resume", pc_c, 8'h22);
        repeat (4) @(negedge clk);
        chk("c_second_hlt", pc_c, 8'h23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/processor_top.md
Name: processor_top

Overview:
8-bit RISC-like CPU core with a 2-stage pipeline: Fetch (IF) and Execute (EX). It has four 8-bit general registers, a Z/C/N flag set, an internal 256x8 instruction ROM, one input port, one output port and one interrupt. It is the top of the processor subsystem, and its debug outputs drive board LEDs and testbenches.

Parameters:
ROM_INIT, "fib.mem", hex file loaded into the instruction ROM; default program is the Fibonacci generator below
INT_VECTOR, 8'hF0, PC value on interrupt entry

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
IN_Port  in  8  external data, read by IN
Interrupt  in  1  interrupt request, level, rising-edge detected
Result_Debug  out  8  last value written to the register file
PC_Debug  out  8  current PC (fetch address)
Valid  out  1  one-cycle strobe, high when OUT_Port is updated
OUT_Port  out  8  output register, written by OUT

Behaviour:
- Reset: rst, synchronous, active-low; clock clk.
- Reset state: PC=0, IR=NOP, R0-R3=0, Z=C=N=0, EPC=0, OUT_Port=0, Valid=0, Result_Debug=0, interrupt pending/mask cleared. A reset asserted mid-program aborts everything on that edge.
- Instruction format: [7:4] opcode, [3:2] ra, [1:0] rb.
- IF: IR <= ROM[PC]; PC <= PC+1 (8-bit wrap 0xFF->0x00). EX executes IR, and all results are registered.
- Opcodes:
  - 0 NOP.
  - 1 MOV: ra<=rb.
  - 2 ADD: ra<=ra+rb.
  - 3 SUB: ra<=ra-rb; C=borrow.
  - 4 AND.
  - 5 OR.
  - 6 INC ra.
  - 7 DEC ra.
  - 8 OUT: OUT_Port<=rb, Valid=1 for one cycle.
  - 9 IN: ra<=IN_Port.
  - A LDM: ra<=ROM[PC], the immediate byte.
  - B JZ: if Z, PC<=rb.
  - C JMP: PC<=rb.
  - D JC: if C, PC<=rb.
  - E RTI.
  - F HLT.
- Flags: ALU ops 2-7 update Z and N (N = result bit 7). C comes from ops 2,3,6,7. Ops 4-5 clear C. All other ops leave flags unchanged.
- Arithmetic is modulo 256; no traps.
- LDM timing: in EX, PC<=PC+1 and IR<=NOP (one bubble).
- Taken branch timing: PC<=target and IR<=NOP (one bubble). A not-taken branch costs no penalty.
- Operands are read from the register file in EX. A single execute stage means no hazards and no forwarding.
- HLT: PC and IR are held until reset or an interrupt is taken.
- Valid is registered and is high only in the cycle following an OUT execution edge. OUT_Port holds its value between OUTs.
- Result_Debug updates on every register-file write (ops 1,2-7,9,A).
- Interrupt entry:
  - A rising edge of Interrupt sets pending when not masked.
  - Entry happens at the end of an EX cycle whose IR is not LDM, a branch, or RTI. The current IR completes, and HLT counts as complete.
  - On entry: EPC<=PC (the fetched-but-discarded address), flags are saved, PC<=INT_VECTOR, IR<=NOP, pending is cleared, mask is set.
- RTI: PC<=EPC, flags restored, mask cleared, IR<=NOP.
- An Interrupt edge while masked is ignored.
- Default ROM contents:
  - 00:A0 01:00 02:A4 03:01 04:AC 05:06
  - 06:80 07:19 08:24 09:12 0A:C3
  - F0:E0
  - All other locations are 00.
- Resulting program: R0=0, R1=1, R3=6; loop { OUT R0; R2=R1; R1+=R0; R0=R2; JMP R3 }.
- Loop period is 6 cycles per output.
- First Valid occurs in the 8th cycle after the first clock edge with rst high.

Decomposition:
- Shared package: opcode localparams, register-index width, INT_VECTOR default, NOP encoding.
- One natural sub-module: proc_alu. It is combinational; inputs are op, a, b, carry-in; outputs are result, Z, C, N.
- Register file, ROM, PC/IR and interrupt logic stay in the top module.

Test Plan:
- Default ROM, reset 2 cycles then release, run 200 cycles. Required: Valid pulses every 6 cycles with OUT_Port = 0,1,1,2,3,5,8,13,21,34,55,89,144,233. The next values wrap modulo 256: 121 (377-256), then 98, and so on.
- Assert rst mid-run. Required: on the next edge PC_Debug=0, OUT_Port=0, Valid=0, and the sequence restarts at 0.
- Pulse Interrupt during the loop. Required: PC_Debug shows F0, then returns to the interrupted address, and the Fibonacci output sequence is unbroken.
- Second Interrupt edge while inside the ISR: ignored, with no re-entry.
- Custom ROM with IN R1 (0x94), OUT R1 (0x81), IN_Port=0x5A. Required: Result_Debug=0x5A, then OUT_Port=0x5A with a one-cycle Valid.
- Custom ROM with LDM R0,FF; INC R0; JC R1 (R1=target 0x20). Required: Z=1, C=1, PC_Debug=0x20 after one bubble.
- Custom ROM with HLT. Required: PC_Debug holds constant. An Interrupt then vectors to F0, and RTI returns to the address after HLT.
